// File: rtl/usb_pkg.sv
// Shared USB constants and types for the packet-level RX/TX state machines.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R   = 16'hA001;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PID     = 3'd1,
    TOK1    = 3'd2,
    TOK2    = 3'd3,
    TOK_EOP = 3'd4,
    HS_EOP  = 3'd5,
    DATA    = 3'd6,
    ERROR   = 3'd7
  } state_RX;

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational CRC16 step over one byte, LSB first, reflected polynomial.
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    logic [15:0] c;
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC16_POLY_R;
      else                  c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/usb_rx_packet_fsm.sv
// Receive packet FSM: SYNC/PID check, token address filter, DATA payload
// streaming with two-byte CRC holdback, and result reporting.
//
// state   | meaning
// IDLE    | waiting for SYNC
// PID     | SYNC seen, expecting PID byte
// TOK1    | token, expecting addr/endp byte
// TOK2    | token, expecting endp/CRC5 byte
// TOK_EOP | token complete, expecting EOP
// HS_EOP  | handshake, expecting EOP
// DATA    | streaming payload, last two bytes held back as CRC
// ERROR   | packet rejected, waiting for next SYNC
module usb_rx_packet_fsm
  import usb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'd0,
  parameter int         MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_RX,
  input  logic       byte_valid,
  input  logic       eop_strobe,
  input  logic       decode_error,
  output logic [3:0] RX_Packet,
  output logic       RX_Packet_Valid,
  output logic       store_RX_Packet_Data,
  output logic [7:0] RX_Packet_Data,
  output logic       Flush,
  output logic       RX_Transfer_Active,
  output logic       RX_Error
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);

  state_RX          state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [6:0]       addr_q, addr_d;
  logic [15:0]      crc_q, crc_d, crc_next;
  logic [7:0]       hold0_q, hold0_d, hold1_q, hold1_d;
  logic [1:0]       hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] payload_cnt_q, payload_cnt_d;
  logic [3:0]       pkt_q, pkt_d;
  logic             valid_q, valid_d;
  logic             push_q, push_d;
  logic [7:0]       data_q, data_d;
  logic             flush_q, flush_d;
  logic             active_q, active_d;
  logic             error_q, error_d;

  logic ev_err, ev_eop, ev_byte;
  logic to_err, to_idle;

  usb_crc16_byte u_crc (
    .crc_i  (crc_q),
    .data_i (byte_RX),
    .crc_o  (crc_next)
  );

  assign ev_err  = decode_error;
  assign ev_eop  = !decode_error && eop_strobe;
  assign ev_byte = !decode_error && !eop_strobe && byte_valid;

  always_comb begin
    state_d       = state_q;
    pid_d         = pid_q;
    addr_d        = addr_q;
    crc_d         = crc_q;
    hold0_d       = hold0_q;
    hold1_d       = hold1_q;
    hold_cnt_d    = hold_cnt_q;
    payload_cnt_d = payload_cnt_q;
    pkt_d         = pkt_q;
    valid_d       = 1'b0;
    push_d        = 1'b0;
    data_d        = data_q;
    flush_d       = 1'b0;
    active_d      = active_q;
    error_d       = error_q;
    to_err        = 1'b0;
    to_idle       = 1'b0;

    case (state_q)
      IDLE, ERROR: begin
        if (ev_byte && byte_RX == SYNC_BYTE) begin
          state_d  = PID;
          active_d = 1'b1;
          error_d  = 1'b0;
        end
      end

      PID: begin
        if (ev_err || ev_eop) begin
          to_err = 1'b1;
        end else if (ev_byte) begin
          if (byte_RX[7:4] != ~byte_RX[3:0]) begin
            to_err = 1'b1;
          end else begin
            pid_d = byte_RX[3:0];
            case (byte_RX[3:0])
              PID_OUT, PID_IN, PID_SETUP: state_d = TOK1;
              PID_DATA0, PID_DATA1: begin
                state_d       = DATA;
                crc_d         = CRC16_INIT;
                hold_cnt_d    = 2'd0;
                payload_cnt_d = '0;
              end
              PID_ACK, PID_NAK, PID_STALL: state_d = HS_EOP;
              default: to_err = 1'b1;
            endcase
          end
        end
      end

      TOK1: begin
        if (ev_err || ev_eop) begin
          to_err = 1'b1;
        end else if (ev_byte) begin
          addr_d  = byte_RX[6:0];
          state_d = TOK2;
        end
      end

      TOK2: begin
        if (ev_err || ev_eop) to_err = 1'b1;
        else if (ev_byte)     state_d = TOK_EOP;
      end

      TOK_EOP: begin
        if (ev_err || ev_byte) begin
          to_err = 1'b1;
        end else if (ev_eop) begin
          to_idle = 1'b1;
          if (addr_q == DEV_ADDR) begin
            valid_d = 1'b1;
            pkt_d   = pid_q;
          end
        end
      end

      HS_EOP: begin
        if (ev_err || ev_byte) begin
          to_err = 1'b1;
        end else if (ev_eop) begin
          to_idle = 1'b1;
          valid_d = 1'b1;
          pkt_d   = pid_q;
        end
      end

      DATA: begin
        if (ev_err) begin
          to_err  = 1'b1;
          flush_d = (payload_cnt_q != '0);
        end else if (ev_eop) begin
          if (hold_cnt_q != 2'd2) begin
            to_err  = 1'b1;
            flush_d = (payload_cnt_q != '0);
          end else if (crc_q == CRC16_RESIDUAL) begin
            to_idle = 1'b1;
            valid_d = 1'b1;
            pkt_d   = pid_q;
          end else begin
            to_err  = 1'b1;
            flush_d = 1'b1;
          end
        end else if (ev_byte) begin
          crc_d = crc_next;
          if (hold_cnt_q == 2'd2) begin
            // The oldest held byte is now known not to be CRC.
            if (payload_cnt_q == CNT_W'(MAX_PAYLOAD)) begin
              to_err  = 1'b1;
              flush_d = 1'b1;
            end else begin
              push_d        = 1'b1;
              data_d        = hold0_q;
              payload_cnt_d = payload_cnt_q + 1'b1;
              hold0_d       = hold1_q;
              hold1_d       = byte_RX;
            end
          end else begin
            if (hold_cnt_q == 2'd0) hold0_d = byte_RX;
            else                    hold1_d = byte_RX;
            hold_cnt_d = hold_cnt_q + 2'd1;
          end
        end
      end

      default: to_idle = 1'b1;
    endcase

    if (to_err) begin
      state_d  = ERROR;
      active_d = 1'b0;
      error_d  = 1'b1;
    end else if (to_idle) begin
      state_d  = IDLE;
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pid_q         <= '0;
      addr_q        <= '0;
      crc_q         <= '0;
      hold0_q       <= '0;
      hold1_q       <= '0;
      hold_cnt_q    <= '0;
      payload_cnt_q <= '0;
      pkt_q         <= '0;
      valid_q       <= 1'b0;
      push_q        <= 1'b0;
      data_q        <= '0;
      flush_q       <= 1'b0;
      active_q      <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pid_q         <= pid_d;
      addr_q        <= addr_d;
      crc_q         <= crc_d;
      hold0_q       <= hold0_d;
      hold1_q       <= hold1_d;
      hold_cnt_q    <= hold_cnt_d;
      payload_cnt_q <= payload_cnt_d;
      pkt_q         <= pkt_d;
      valid_q       <= valid_d;
      push_q        <= push_d;
      data_q        <= data_d;
      flush_q       <= flush_d;
      active_q      <= active_d;
      error_q       <= error_d;
    end
  end

  assign RX_Packet            = pkt_q;
  assign RX_Packet_Valid      = valid_q;
  assign store_RX_Packet_Data = push_q;
  assign RX_Packet_Data       = data_q;
  assign Flush                = flush_q;
  assign RX_Transfer_Active   = active_q;
  assign RX_Error             = error_q;

endmodule

// File: tb/tb_usb_rx_packet_fsm.sv
// Directed bench for usb_rx_packet_fsm: vector table plus multi-cycle corner sequences.
module tb_usb_rx_packet_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_RX = 8'h00;
  logic       byte_valid = 1'b0;
  logic       eop_strobe = 1'b0;
  logic       decode_error = 1'b0;
  logic [3:0] RX_Packet;
  logic       RX_Packet_Valid;
  logic       store_RX_Packet_Data;
  logic [7:0] RX_Packet_Data;
  logic       Flush;
  logic       RX_Transfer_Active;
  logic       RX_Error;

  int n_cmp = 0;
  int n_bad = 0;

  int n_valid = 0;
  int n_push  = 0;
  int n_flush = 0;
  logic [7:0] pushed[$];

  always #5 clk = ~clk;

  usb_rx_packet_fsm #(.DEV_ADDR(7'd5), .MAX_PAYLOAD(64)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .byte_RX              (byte_RX),
    .byte_valid           (byte_valid),
    .eop_strobe           (eop_strobe),
    .decode_error         (decode_error),
    .RX_Packet            (RX_Packet),
    .RX_Packet_Valid      (RX_Packet_Valid),
    .store_RX_Packet_Data (store_RX_Packet_Data),
    .RX_Packet_Data       (RX_Packet_Data),
    .Flush                (Flush),
    .RX_Transfer_Active   (RX_Transfer_Active),
    .RX_Error             (RX_Error)
  );

  always @(negedge clk) begin
    if (RX_Packet_Valid) n_valid++;
    if (Flush) n_flush++;
    if (store_RX_Packet_Data) begin
      n_push++;
      pushed.push_back(RX_Packet_Data);
    end
  end

  typedef struct {
    string       name;
    logic [63:0] bytes;   // first byte in bits [63:56]
    int          n;
    bit          eop;
    int          exp_valid;
    logic [3:0]  exp_pkt;
    int          exp_push;
    int          exp_flush;
    bit          exp_err;
  } vec_t;

  vec_t vecs[16];
  int   n_vecs;

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] != d[i]) r = {1'b0, r[15:1]} ^ 16'hA001;
      else              r = {1'b0, r[15:1]};
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_RX = b; byte_valid = 1'b1; eop_strobe = 1'b0; decode_error = 1'b0;
  endtask

  task automatic send_eop();
    @(negedge clk);
    byte_valid = 1'b0; eop_strobe = 1'b1; decode_error = 1'b0;
  endtask

  task automatic send_derr();
    @(negedge clk);
    byte_valid = 1'b0; eop_strobe = 1'b0; decode_error = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      byte_valid = 1'b0; eop_strobe = 1'b0; decode_error = 1'b0;
    end
  endtask

  initial begin
    int bv, bp, bf;
    logic [15:0] c;
    logic [7:0] payload[$];

    n_vecs = 0;
    vecs[n_vecs++] = '{"garbage",   64'h1122_0000_0000_0000, 2, 1, 0, 4'h0, 0, 0, 0};
    vecs[n_vecs++] = '{"ack",       64'h80D2_0000_0000_0000, 2, 1, 1, 4'h2, 0, 0, 0};
    vecs[n_vecs++] = '{"data0_zl",  64'h80C3_0000_0000_0000, 4, 1, 1, 4'h3, 0, 0, 0};
    vecs[n_vecs++] = '{"nak",       64'h805A_0000_0000_0000, 2, 1, 1, 4'hA, 0, 0, 0};
    vecs[n_vecs++] = '{"stall",     64'h801E_0000_0000_0000, 2, 1, 1, 4'hE, 0, 0, 0};
    vecs[n_vecs++] = '{"bad_pid",   64'h80C4_0000_0000_0000, 2, 1, 0, 4'hE, 0, 0, 1};
    vecs[n_vecs++] = '{"in_addr6",  64'h8069_0600_0000_0000, 4, 1, 0, 4'hE, 0, 0, 0};
    vecs[n_vecs++] = '{"in_addr5",  64'h8069_0500_0000_0000, 4, 1, 1, 4'h9, 0, 0, 0};
    vecs[n_vecs++] = '{"out_endp",  64'h80E1_8537_0000_0000, 4, 1, 1, 4'h1, 0, 0, 0};
    vecs[n_vecs++] = '{"setup",     64'h802D_0500_0000_0000, 4, 1, 1, 4'hD, 0, 0, 0};
    vecs[n_vecs++] = '{"hs_extra",  64'h80D2_0000_0000_0000, 3, 1, 0, 4'hD, 0, 0, 1};
    vecs[n_vecs++] = '{"tok_short", 64'h8069_0000_0000_0000, 2, 1, 0, 4'hD, 0, 0, 1};
    vecs[n_vecs++] = '{"pid_rsvd",  64'h80F0_0000_0000_0000, 2, 1, 0, 4'hD, 0, 0, 1};
    vecs[n_vecs++] = '{"data_1b",   64'h80C3_1100_0000_0000, 3, 1, 0, 4'hD, 0, 0, 1};
    vecs[n_vecs++] = '{"tok_xbyte", 64'h8069_0500_7700_0000, 5, 1, 0, 4'hD, 0, 0, 1};

    repeat (2) @(negedge clk);
    chk("rst_pkt",    RX_Packet, 0);
    chk("rst_valid",  RX_Packet_Valid, 0);
    chk("rst_push",   store_RX_Packet_Data, 0);
    chk("rst_flush",  Flush, 0);
    chk("rst_active", RX_Transfer_Active, 0);
    chk("rst_err",    RX_Error, 0);
    rst = 1'b0;

    for (int v = 0; v < n_vecs; v++) begin
      bv = n_valid; bp = n_push; bf = n_flush;
      for (int j = 0; j < vecs[v].n; j++) send(vecs[v].bytes[63 - 8*j -: 8]);
      if (vecs[v].eop) send_eop();
      idle(2);
      chk({vecs[v].name, "_valid"},  n_valid - bv, vecs[v].exp_valid);
      chk({vecs[v].name, "_pkt"},    RX_Packet, vecs[v].exp_pkt);
      chk({vecs[v].name, "_push"},   n_push - bp, vecs[v].exp_push);
      chk({vecs[v].name, "_flush"},  n_flush - bf, vecs[v].exp_flush);
      chk({vecs[v].name, "_err"},    RX_Error, vecs[v].exp_err);
      chk({vecs[v].name, "_active"}, RX_Transfer_Active, 0);
    end

    // ACK timing: valid exactly one cycle after EOP, active while in packet
    send(8'h80);
    @(negedge clk); byte_valid = 1'b0;
    chk("sync_active", RX_Transfer_Active, 1);
    chk("sync_err_clr", RX_Error, 0);
    send(8'hD2);
    send_eop();
    @(negedge clk); eop_strobe = 1'b0;
    chk("ack_valid_t1", RX_Packet_Valid, 1);
    chk("ack_active_t1", RX_Transfer_Active, 0);
    @(negedge clk);
    chk("ack_valid_pulse", RX_Packet_Valid, 0);

    // DATA1 01 02 03 with correct CRC
    payload = '{8'h01, 8'h02, 8'h03};
    c = 16'hFFFF;
    foreach (payload[i]) c = crc16(c, payload[i]);
    c = ~c;
    bv = n_valid; bp = n_push; bf = n_flush;
    pushed.delete();
    send(8'h80); send(8'h4B);
    foreach (payload[i]) send(payload[i]);
    send(c[7:0]); send(c[15:8]);
    send_eop(); idle(2);
    chk("d1_push", n_push - bp, 3);
    chk("d1_b0", pushed.size() > 0 ? int'(pushed[0]) : -1, 8'h01);
    chk("d1_b1", pushed.size() > 1 ? int'(pushed[1]) : -1, 8'h02);
    chk("d1_b2", pushed.size() > 2 ? int'(pushed[2]) : -1, 8'h03);
    chk("d1_valid", n_valid - bv, 1);
    chk("d1_pkt", RX_Packet, 4'hB);
    chk("d1_flush", n_flush - bf, 0);
    chk("d1_err", RX_Error, 0);

    // same packet, last CRC byte inverted
    bv = n_valid; bp = n_push; bf = n_flush;
    send(8'h80); send(8'h4B);
    foreach (payload[i]) send(payload[i]);
    send(c[7:0]); send(~c[15:8]);
    send_eop(); idle(2);
    chk("badcrc_push", n_push - bp, 3);
    chk("badcrc_flush", n_flush - bf, 1);
    chk("badcrc_valid", n_valid - bv, 0);
    chk("badcrc_err", RX_Error, 1);
    chk("badcrc_pkt", RX_Packet, 4'hB);
    send(8'h80); idle(1);
    chk("sync_clears_err", RX_Error, 0);
    send(8'hD2); send_eop(); idle(2);

    // overflow: 66 payload + 2 CRC bytes with MAX_PAYLOAD = 64
    bv = n_valid; bp = n_push; bf = n_flush;
    pushed.delete();
    send(8'h80); send(8'hC3);
    for (int i = 0; i < 68; i++) send(8'(i));
    send_eop(); idle(2);
    chk("ovf_push", n_push - bp, 64);
    chk("ovf_first", pushed.size() > 0 ? int'(pushed[0]) : -1, 0);
    chk("ovf_last", pushed.size() > 63 ? int'(pushed[63]) : -1, 63);
    chk("ovf_flush", n_flush - bf, 1);
    chk("ovf_valid", n_valid - bv, 0);
    chk("ovf_err", RX_Error, 1);

    // decode_error mid-DATA
    bv = n_valid; bp = n_push; bf = n_flush;
    send(8'h80); send(8'hC3);
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
    send_derr(); idle(2);
    chk("derr_push", n_push - bp, 3);
    chk("derr_flush", n_flush - bf, 1);
    chk("derr_err", RX_Error, 1);
    chk("derr_active", RX_Transfer_Active, 0);

    // priority: decode_error beats EOP in HS_EOP
    bv = n_valid;
    send(8'h80); send(8'hD2);
    @(negedge clk); byte_valid = 1'b0; eop_strobe = 1'b1; decode_error = 1'b1;
    idle(2);
    chk("prio_derr_valid", n_valid - bv, 0);
    chk("prio_derr_err", RX_Error, 1);

    // priority: EOP beats byte in HS_EOP
    bv = n_valid;
    send(8'h80); send(8'h5A);
    @(negedge clk); byte_RX = 8'h00; byte_valid = 1'b1; eop_strobe = 1'b1; decode_error = 1'b0;
    idle(2);
    chk("prio_eop_valid", n_valid - bv, 1);
    chk("prio_eop_pkt", RX_Packet, 4'hA);
    chk("prio_eop_err", RX_Error, 0);

    // reset mid-DATA
    bf = n_flush;
    send(8'h80); send(8'hC3);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    @(negedge clk); byte_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rstm_pkt", RX_Packet, 0);
    chk("rstm_push", store_RX_Packet_Data, 0);
    chk("rstm_data", RX_Packet_Data, 0);
    chk("rstm_active", RX_Transfer_Active, 0);
    chk("rstm_err", RX_Error, 0);
    idle(2);
    chk("rstm_flush", n_flush - bf, 0);
    bv = n_valid;
    send(8'h80); send(8'hD2); send_eop(); idle(2);
    chk("rstm_recover", n_valid - bv, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
